// File: rtl/stream_arb2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arb2_pkg
//  Description : Shared types and constants for the two-input stream arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_arb2_pkg;

    // Arbiter control states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,   // no packet in progress
        ST_LOCK = 1'b1    // packet in progress, output owned by one input
    } state_t;

    // Input stream indices (also the value driven on the mux select)
    localparam logic IN0 = 1'b0;
    localparam logic IN1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux2to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux2to1
//  Description : Single-bit 2:1 multiplexer cell (sel=0 -> a, sel=1 -> b).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic out
);

    assign out = sel ? b : a;

endmodule
`default_nettype wire

// File: rtl/stream_reg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_reg
//  Description : Valid/ready output pipeline register. Holds the beat, its
//                last flag and source index; reports when it can take a beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_sel,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_sel,
    output logic              o_space
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_sel;
    logic              w_space;

    // Register is free when empty or when its current beat leaves this cycle
    assign w_space = !r_valid || i_ready;

    // Load a new beat (overwriting a draining one) or empty out once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_sel   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
            r_sel   <= i_sel;
        end else if (w_space) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_sel   = r_sel;
    assign o_space = w_space;

endmodule
`default_nettype wire

// File: rtl/stream_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : stream_arb2
//  Description : Two-input round-robin stream arbiter with packet locking.
//                Drives the 2:1 datapath mux select and a registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_arb2
    import stream_arb2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              sel
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              w_prio_nxt;
    logic              r_lock_id;
    logic              w_lock_nxt;

    logic              w_grant;
    logic              w_has_grant;
    logic              w_grant_valid;
    logic              w_space;
    logic              w_accept;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_last;

    // Grant decision: locked owner in ST_LOCK, round-robin among valid inputs otherwise
    always_comb begin
        w_has_grant = 1'b0;
        w_grant     = r_prio;
        if (r_state == ST_LOCK) begin
            w_has_grant = 1'b1;
            w_grant     = r_lock_id;
        end else if (in0_valid && in1_valid) begin
            w_has_grant = 1'b1;
            w_grant     = r_prio;
        end else if (in0_valid) begin
            w_has_grant = 1'b1;
            w_grant     = IN0;
        end else if (in1_valid) begin
            w_has_grant = 1'b1;
            w_grant     = IN1;
        end
    end

    // Readies are forced low while reset is held so nothing is taken during reset
    assign in0_ready     = rst_n && w_has_grant && (w_grant == IN0) && w_space;
    assign in1_ready     = rst_n && w_has_grant && (w_grant == IN1) && w_space;
    assign w_grant_valid = (w_grant == IN1) ? in1_valid : in0_valid;
    assign w_accept      = w_has_grant && w_grant_valid && w_space;

    // Datapath select: one mux cell per data bit, steered by the grant
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_mux
            mux2to1 u_mux (
                .a   (in0_data[gi]),
                .b   (in1_data[gi]),
                .sel (w_grant),
                .out (w_sel_data[gi])
            );
        end
    endgenerate

    mux2to1 u_last_mux (
        .a   (in0_last),
        .b   (in1_last),
        .sel (w_grant),
        .out (w_sel_last)
    );

    // Next-state: lock on a non-final first beat, rotate priority on packet end
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_lock_nxt  = r_lock_id;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_last) begin
                        w_prio_nxt = ~w_grant;
                    end else begin
                        w_state_nxt = ST_LOCK;
                        w_lock_nxt  = w_grant;
                    end
                end
                ST_LOCK: begin
                    if (w_sel_last) begin
                        w_state_nxt = ST_IDLE;
                        w_prio_nxt  = ~r_lock_id;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_prio    <= IN0;
            r_lock_id <= IN0;
        end else begin
            r_state   <= w_state_nxt;
            r_prio    <= w_prio_nxt;
            r_lock_id <= w_lock_nxt;
        end
    end

    stream_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_data  (w_sel_data),
        .i_last  (w_sel_last),
        .i_sel   (w_grant),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last),
        .o_sel   (sel),
        .o_space (w_space)
    );

endmodule
`default_nettype wire

// File: tb/tb_stream_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_arb2
//  Description : Self-checking bench for stream_arb2 (behavioural model plus
//                directed literal expectations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_arb2;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in0_valid, in0_ready, in0_last;
    logic              in1_valid, in1_ready, in1_last;
    logic [DATA_W-1:0] in0_data, in1_data;
    logic              out_valid, out_ready, out_last, sel;
    logic [DATA_W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    stream_arb2 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 when no packet is in progress, else the input that owns the output
    int              m_owner = -1;
    int              m_prio  = 0;
    logic            m_ov = 1'b0, m_ol = 1'b0, m_os = 1'b0;
    logic [DATA_W-1:0] m_od = '0;

    function automatic logic vld(input int i);
        return (i == 0) ? in0_valid : in1_valid;
    endfunction

    function automatic logic [DATA_W-1:0] dat(input int i);
        return (i == 0) ? in0_data : in1_data;
    endfunction

    function automatic logic lst(input int i);
        return (i == 0) ? in0_last : in1_last;
    endfunction

    function automatic int m_grant();
        if (m_owner >= 0)           return m_owner;
        if (in0_valid && in1_valid) return m_prio;
        if (in0_valid)              return 0;
        if (in1_valid)              return 1;
        return -1;
    endfunction

    function automatic logic m_space();
        return !m_ov || out_ready;
    endfunction

    function automatic logic m_ready(input int i);
        return rst_n && m_space() && (m_grant() == i);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_prio  <= 0;
            m_ov    <= 1'b0;
            m_od    <= '0;
            m_ol    <= 1'b0;
            m_os    <= 1'b0;
        end else if (m_grant() >= 0 && vld(m_grant()) && m_space()) begin
            m_ov <= 1'b1;
            m_od <= dat(m_grant());
            m_ol <= lst(m_grant());
            m_os <= (m_grant() == 1);
            if (lst(m_grant())) begin
                m_owner <= -1;
                m_prio  <= 1 - m_grant();
            end else begin
                m_owner <= m_grant();
            end
        end else if (m_space()) begin
            m_ov <= 1'b0;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data",  32'(out_data),  32'(m_od));
        chk("out_last",  32'(out_last),  32'(m_ol));
        chk("sel",       32'(sel),       32'(m_os));
        chk("in0_ready", 32'(in0_ready), 32'(m_ready(0)));
        chk("in1_ready", 32'(in1_ready), 32'(m_ready(1)));
    end

    // Watchdog so the run always ends
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 5000) begin
            n_fail++;
            $display("FAIL watchdog: got %0d cycles expected at most 5000", cyc);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "watchdog expired");
        end
    end

    // ---------------- stimulus ----------------
    // Each queue entry is {last, data}; hold forces an input's valid low
    logic [DATA_W:0] q0[$];
    logic [DATA_W:0] q1[$];
    logic            hold0 = 1'b0, hold1 = 1'b0;
    logic [7:0]      exp_lock [4] = '{8'h11, 8'h12, 8'h13, 8'h55};

    task automatic drive();
        in0_valid = !hold0 && (q0.size() > 0);
        in1_valid = !hold1 && (q1.size() > 0);
        if (q0.size() > 0) {in0_last, in0_data} = q0[0];
        if (q1.size() > 0) {in1_last, in1_data} = q1[0];
    endtask

    // One clock: note what was accepted, step past the edge, present next beats
    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        a0 = in0_valid && in0_ready;
        a1 = in1_valid && in1_ready;
        @(posedge clk);
        #1;
        if (a0 && q0.size() > 0) void'(q0.pop_front());
        if (a1 && q1.size() > 0) void'(q1.pop_front());
        drive();
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in0_data  = '0;
        in1_data  = '0;
        in0_last  = 1'b0;
        in1_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            q0.push_back({1'b1, 8'(8'hA0 + k)});
            q1.push_back({1'b1, 8'(8'hB0 + k)});
        end
        drive();

        // Reset held with both inputs valid
        repeat (3) cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_grant_in0", 32'(in0_ready), 32'd1);
        chk("first_grant_in1", 32'(in1_ready), 32'd0);

        // Contention: single-beat packets alternate A0,B0,A1,B1,...
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_data", 32'(out_data), (k % 2 == 0) ? 32'(8'hA0 + k / 2) : 32'(8'hB0 + k / 2));
            chk("rr_sel",  32'(sel),      32'(k % 2));
        end

        // Packet lock: in0 3-beat packet, in1 waits
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h12});
        q0.push_back({1'b1, 8'h13});
        q1.push_back({1'b1, 8'h55});
        drive();
        #1;
        chk("lock_in1_ready", 32'(in1_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("lock_data", 32'(out_data), 32'(exp_lock[k]));
            if (k < 2) chk("lock_in1_ready", 32'(in1_ready), 32'd0);
        end

        // Back-pressure: output held for 4 cycles, nothing lost afterwards
        for (int k = 0; k < 3; k++) q1.push_back({1'b1, 8'(8'h60 + k)});
        drive();
        cycle();
        chk("bp_first", 32'(out_data), 32'h60);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("bp_hold_data",  32'(out_data),  32'h60);
            chk("bp_hold_sel",   32'(sel),       32'd1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in0_ready",  32'(in0_ready), 32'd0);
            chk("bp_in1_ready",  32'(in1_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        cycle();
        chk("bp_resume0", 32'(out_data), 32'h61);
        cycle();
        chk("bp_resume1", 32'(out_data), 32'h62);

        // Lock gap: in0 pauses mid-packet, in1 must not slip in
        q0.push_back({1'b0, 8'h21});
        q0.push_back({1'b1, 8'h22});
        q1.push_back({1'b1, 8'h77});
        drive();
        cycle();
        chk("gap_first", 32'(out_data), 32'h21);
        hold0 = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("gap_in1_ready", 32'(in1_ready), 32'd0);
            chk("gap_empty",     32'(out_valid), 32'd0);
        end
        hold0 = 1'b0;
        drive();
        #1;
        cycle();
        chk("gap_last",     32'(out_data), 32'h22);
        chk("gap_last_sel", 32'(sel),      32'd0);
        cycle();
        chk("gap_in1",      32'(out_data), 32'h77);
        chk("gap_in1_sel",  32'(sel),      32'd1);

        // Reset in the middle of an in1 packet
        q1.push_back({1'b0, 8'h31});
        q1.push_back({1'b0, 8'h32});
        q1.push_back({1'b1, 8'h33});
        drive();
        cycle();
        chk("mid_beat0", 32'(out_data), 32'h31);
        cycle();
        chk("mid_beat1", 32'(out_data), 32'h32);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_in1_rd", 32'(in1_ready), 32'd0);
        q0.push_back({1'b1, 8'h41});
        drive();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in0_ready", 32'(in0_ready), 32'd1);
        chk("post_rst_in1_ready", 32'(in1_ready), 32'd0);
        cycle();
        chk("post_rst_data", 32'(out_data), 32'h41);
        chk("post_rst_sel",  32'(sel),      32'd0);
        cycle();
        chk("post_rst_in1",  32'(out_data), 32'h33);
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
